// File: rtl/srt4_pkg.sv
// Shared types and constants for the SRT radix-4 datapath blocks.
package srt4_pkg;

   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] data_t;

   localparam logic SEL_OUT0 = 1'b0;
   localparam logic SEL_OUT1 = 1'b1;

endpackage : srt4_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register-array storage, separate occupancy count
// and a head output that reads as zero while empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   input  logic                     pop,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = count_q;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never cleared; the reset pointers/count make stale words unreachable.
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule : sync_fifo

// File: rtl/demux_buf.sv
// Registered 1-to-2 stream demultiplexer: sel steers each accepted word
// into one of two independent output FIFOs.
module demux_buf
   import srt4_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       data_out0,
   output logic [WIDTH-1:0]       data_out1,
   output logic                   out0_valid,
   output logic                   out1_valid,
   input  logic                   out0_ready,
   input  logic                   out1_ready,
   output logic [$clog2(DEPTH):0] count0,
   output logic [$clog2(DEPTH):0] count1
);

   logic                   push_w  [2];
   logic                   pop_w   [2];
   logic                   full_w  [2];
   logic                   empty_w [2];
   logic [$clog2(DEPTH):0] count_w [2];
   logic [WIDTH-1:0]       head_w  [2];

   // Ready reflects only the selected FIFO, so it never depends on in_valid.
   assign in_ready  = (sel == SEL_OUT1) ? !full_w[1] : !full_w[0];
   assign push_w[0] = in_valid && in_ready && (sel == SEL_OUT0);
   assign push_w[1] = in_valid && in_ready && (sel == SEL_OUT1);
   assign pop_w[0]  = out0_ready;
   assign pop_w[1]  = out1_ready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
         sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_w[gi]),
            .din   (data_in),
            .full  (full_w[gi]),
            .pop   (pop_w[gi]),
            .empty (empty_w[gi]),
            .count (count_w[gi]),
            .head  (head_w[gi])
         );
      end
   endgenerate

   assign data_out0  = head_w[0];
   assign data_out1  = head_w[1];
   assign out0_valid = !empty_w[0];
   assign out1_valid = !empty_w[1];
   assign count0     = count_w[0];
   assign count1     = count_w[1];

endmodule : demux_buf

// File: tb/tb_demux_buf.sv
// Directed self-checking bench for demux_buf with hand-computed expectations.
module tb_demux_buf;
   import srt4_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   data_t      data_in;
   logic       sel;
   logic       in_valid;
   logic       in_ready;
   data_t      data_out0, data_out1;
   logic       out0_valid, out1_valid;
   logic       out0_ready, out1_ready;
   logic [1:0] count0, count1;

   int n_total = 0;
   int n_pass  = 0;

   demux_buf #(.WIDTH(8), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .sel        (sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_out0  (data_out0),
      .data_out1  (data_out1),
      .out0_valid (out0_valid),
      .out1_valid (out1_valid),
      .out0_ready (out0_ready),
      .out1_ready (out1_ready),
      .count0     (count0),
      .count1     (count1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
      $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one rising edge, then settle 1 time unit for sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; data_in = '0; sel = 1'b0; in_valid = 1'b0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_count0", 32'(count0), 0);
      chk("rst_count1", 32'(count1), 0);
      chk("rst_valid0", 32'(out0_valid), 0);
      chk("rst_valid1", 32'(out1_valid), 0);
      chk("rst_data0",  32'(data_out0), 0);
      chk("rst_data1",  32'(data_out1), 0);
      chk("rst_rdy_s0", 32'(in_ready), 1);
      sel = 1'b1; #1;
      chk("rst_rdy_s1", 32'(in_ready), 1);

      // Single word to output 0
      data_in = 8'd15; sel = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("w15_valid0", 32'(out0_valid), 1);
      chk("w15_data0",  32'(data_out0), 15);
      chk("w15_valid1", 32'(out1_valid), 0);
      chk("w15_count0", 32'(count0), 1);
      out0_ready = 1'b1;
      tick();
      out0_ready = 1'b0;
      chk("w15_drained", 32'(count0), 0);

      // Single word through output 1 with consumer ready
      out1_ready = 1'b1;
      data_in = 8'd5; sel = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("w5_valid1", 32'(out1_valid), 1);
      chk("w5_data1",  32'(data_out1), 5);
      tick();
      chk("w5_gone",   32'(out1_valid), 0);
      chk("w5_count1", 32'(count1), 0);

      // Fill output 0, then route around it
      sel = 1'b0; data_in = 8'h11; in_valid = 1'b1;
      tick();
      data_in = 8'h22;
      tick();
      in_valid = 1'b0; #1;
      chk("full_count0", 32'(count0), 2);
      chk("full_rdy_s0", 32'(in_ready), 0);
      sel = 1'b1; data_in = 8'h33; in_valid = 1'b1; #1;
      chk("byp_rdy_s1", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("byp_data1",  32'(data_out1), 8'h33);
      chk("byp_valid1", 32'(out1_valid), 1);
      chk("byp_head0",  32'(data_out0), 8'h11);

      // Full plus pop: offered word rejected that cycle, accepted the next
      sel = 1'b0; data_in = 8'h44; in_valid = 1'b1; out0_ready = 1'b1; #1;
      chk("fp_rdy",     32'(in_ready), 0);
      tick();
      chk("fp_head0",   32'(data_out0), 8'h22);
      chk("fp_count0",  32'(count0), 1);
      chk("fp_rdy_nxt", 32'(in_ready), 1);
      chk("fp_count1",  32'(count1), 0);
      tick();
      in_valid = 1'b0;
      chk("fp_head44",  32'(data_out0), 8'h44);
      chk("fp_cnt_pp",  32'(count0), 1);
      tick();
      chk("fp_empty0",  32'(count0), 0);

      // Alternating stream with both consumers ready
      out0_ready = 1'b1; out1_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         data_in = 8'(i); sel = 1'((i - 1) & 1); in_valid = 1'b1; #1;
         chk($sformatf("st%0d_rdy", i), 32'(in_ready), 1);
         tick();
         if (sel == SEL_OUT0) begin
            chk($sformatf("st%0d_data0", i), 32'(data_out0), i);
            chk($sformatf("st%0d_cnt0", i),  32'(count0), 1);
         end else begin
            chk($sformatf("st%0d_data1", i), 32'(data_out1), i);
            chk($sformatf("st%0d_cnt1", i),  32'(count1), 1);
         end
      end
      in_valid = 1'b0;
      tick();
      chk("st_end_v0", 32'(out0_valid), 0);
      chk("st_end_v1", 32'(out1_valid), 0);

      // Fill both, then reset with a word on offer
      out0_ready = 1'b0; out1_ready = 1'b0;
      in_valid = 1'b1;
      sel = 1'b0; data_in = 8'hA0; tick();
      data_in = 8'hA1; tick();
      sel = 1'b1; data_in = 8'hB0; tick();
      data_in = 8'hB1; tick();
      in_valid = 1'b0;
      chk("fill_cnt0", 32'(count0), 2);
      chk("fill_cnt1", 32'(count1), 2);
      rst = 1'b1; sel = 1'b1; data_in = 8'hCC; in_valid = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("mrst_cnt0",  32'(count0), 0);
      chk("mrst_cnt1",  32'(count1), 0);
      chk("mrst_v0",    32'(out0_valid), 0);
      chk("mrst_v1",    32'(out1_valid), 0);
      chk("mrst_d0",    32'(data_out0), 0);
      chk("mrst_d1",    32'(data_out1), 0);
      data_in = 8'h5A; sel = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_d1",    32'(data_out1), 8'h5A);
      chk("post_cnt1",  32'(count1), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_demux_buf

// File: doc/demux_buf.md
# demux_buf

Registered 1-to-2 stream demultiplexer: the inverse of the 2-to-1 `mux` datapath selector. A single `WIDTH`-bit input stream with a valid/ready handshake is steered by `sel` into one of two independent output FIFOs, and each FIFO drains through its own valid/ready port. It sits between the operand source and the two consumers of the SRT radix-4 datapath, for example the dividend and divisor operand registers. Buffering decouples the consumers from the producer.

## Interface
- `WIDTH`, 8, data width of the input and both outputs
- `DEPTH`, 2, entries per output FIFO; power of two, ≥ 2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `data_in`  in  WIDTH  input word
- `sel`  in  1  route select: 0 → output 0, 1 → output 1; sampled with `data_in`
- `in_valid`  in  1  `data_in`/`sel` valid
- `in_ready`  out  1  selected FIFO can accept this cycle
- `data_out0` / `data_out1`  out  WIDTH  head entry of FIFO 0 / 1
- `out0_valid` / `out1_valid`  out  1  FIFO 0 / 1 non-empty
- `out0_ready` / `out1_ready`  in  1  consumer 0 / 1 takes head
- `count0` / `count1`  out  $clog2(DEPTH)+1  occupancy of FIFO 0 / 1

## Operation
- Push: `in_valid && in_ready` writes `data_in` into FIFO[`sel`]. The other FIFO is untouched.
- `in_ready` is combinational: `sel ? !full1 : !full0`. It depends on `sel` and never on `in_valid`.
- Pop per FIFO: `outN_valid && outN_ready` advances the read pointer. Ready while not valid is ignored.
- `outN_valid = (countN != 0)`. `data_outN` is the head entry when valid and is forced to 0 when empty.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. The count is tracked separately, range 0..DEPTH.
- Full FIFO plus pop in the same cycle: `in_ready` is still 0 and there is no push. The count decrements.
- Empty FIFO plus push in the same cycle: no fall-through. The word appears the next cycle.
- Push and pop in the same cycle on a non-empty, non-full FIFO: the count is unchanged and both pointers advance.
- Output sides are independent: a stalled output N never blocks traffic routed to the other output.
- Ordering is preserved per output. There is no ordering relation between the outputs.
- `rst` asserted mid-operation clears both FIFOs on that edge, and buffered data is discarded. A handshake in the reset cycle is ignored.

## Timing
- Reset values: `count0 = count1 = 0`, `out0_valid = out1_valid = 0`, `data_out0 = data_out1 = 0`.
- `in_ready` after reset is 1 for either value of `sel`.
- Latency is 1 cycle: a word accepted at edge k is presented as `data_outN`/`outN_valid` after edge k.
- Throughput is 1 word/cycle sustained into each output whose consumer holds ready high.
- `outN_valid`, `data_outN` and `countN` are registered or derived from registered state only, with no path from inputs.
- `in_ready` has a combinational path from `sel` only.
- Input-side rule: once `in_valid` is raised, the producer holds `data_in`/`sel` stable until accepted.
- Output-side rule: `outN_valid` never drops without a pop, and `data_outN` is stable while `outN_valid && !outN_ready`.

## Structure
- Shared package `srt4_pkg`:
  - constant `DATA_W = 8`, used as the `WIDTH` default;
  - typedef `data_t` (`logic [DATA_W-1:0]`);
  - `localparam` `SEL_OUT0 = 1'b0` and `SEL_OUT1 = 1'b1`.
- Sub-module `sync_fifo` (`WIDTH`, `DEPTH`; push/full, pop/empty/count, head data) is instantiated twice.
  - The top level holds only the routing logic for push enables and `in_ready`.
- Register array storage (no RAM macro), reset only on pointers and counts.

## Test plan
- Reset, then `data_in = 15`, `sel = 0`, valid for 1 cycle → next cycle `out0_valid = 1`, `data_out0 = 15`, `out1_valid = 0`, `count0 = 1`.
- `data_in = 5`, `sel = 1` with `out1_ready = 1` held → `data_out1 = 5` for one cycle, then `out1_valid = 0`, `count1 = 0`.
- `out0_ready = 0`; push 0x11, 0x22 to output 0 → `count0 = 2` and `in_ready = 0` while `sel = 0`.
  - Then `sel = 1`, push 0x33 → accepted, `data_out1 = 0x33`.
  - Output 0 still holds 0x11 at its head.
- Output 0 full; assert `out0_ready` and offer 0x44 (`sel = 0`) in the same cycle → 0x11 pops, 0x44 is not accepted.
  - Next cycle `in_ready = 1`, and 0x44 is accepted.
  - Drain order is 0x22, 0x44.
- Stream 0x01..0x08 alternating `sel` with both readies high → each output sees its words in order, with 1-cycle latency and no bubbles on the input.
- Fill both FIFOs, assert `rst` for 1 cycle while `in_valid = 1` → next cycle counts are 0, valids are 0, data outputs are 0, and the offered word is not stored.
